// File: rtl/iomem_slot_arbiter_if.sv
// PicoSoC iomem bus plus the peripheral slot bank it is sequenced onto.
// The slave modport is the arbiter's view; master is the CPU/peripheral side.
interface iomem_slot_arbiter_if #(
  parameter int unsigned NUM_SLOTS = 8
);
  logic                      iomem_valid;
  logic                      iomem_ready;
  logic [3:0]                iomem_wstrb;
  logic [31:0]               iomem_addr;
  logic [31:0]               iomem_wdata;
  logic [31:0]               iomem_rdata;
  logic [NUM_SLOTS-1:0]      p_sel;
  logic [3:0]                p_wstrb;
  logic [7:0]                p_addr;
  logic [31:0]               p_wdata;
  logic [32*NUM_SLOTS-1:0]   p_rdata;
  logic [NUM_SLOTS-1:0]      p_ready;

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, p_rdata, p_ready,
    output iomem_ready, iomem_rdata, p_sel, p_wstrb, p_addr, p_wdata
  );

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, p_rdata, p_ready,
    input  iomem_ready, iomem_rdata, p_sel, p_wstrb, p_addr, p_wdata
  );
endinterface

// File: rtl/iomem_slot_arbiter.sv
// Decodes one iomem window into NUM_SLOTS peripheral slots, one transaction at a time,
// with error responses for unmapped slots and stalled peripherals.
module iomem_slot_arbiter #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0300,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    reset,
  iomem_slot_arbiter_if.slave     bus,
  output logic [7:0]              err_count,
  output logic [31:0]             last_err_addr
);

  typedef enum logic [1:0] {StIdle, StAccess, StError, StResp} state_e;

  localparam logic [7:0] TimeoutM1 = 8'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [NUM_SLOTS-1:0] p_sel_q, p_sel_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic [31:0]          last_err_q, last_err_d;

  logic [31:0]          slot_rdata;
  logic                 sel_ready;
  logic                 slot_mapped;

  // p_sel_q is one-hot and held for the whole access, so it doubles as the slot mux select.
  always_comb begin
    slot_rdata = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (p_sel_q[i]) slot_rdata = bus.p_rdata[32*i +: 32];
    end
  end

  assign sel_ready   = |(bus.p_ready & p_sel_q);
  assign slot_mapped = {24'd0, bus.iomem_addr[15:8]} < NUM_SLOTS;

  always_comb begin
    state_d    = state_q;
    p_sel_d    = p_sel_q;
    wstrb_d    = wstrb_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    err_cnt_d  = err_cnt_q;
    last_err_d = last_err_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.iomem_valid && bus.iomem_addr[31:16] == BASE_ADDR) begin
          wstrb_d = bus.iomem_wstrb;
          addr_d  = bus.iomem_addr;
          wdata_d = bus.iomem_wdata;
          if (slot_mapped) begin
            p_sel_d = NUM_SLOTS'(1) << bus.iomem_addr[15:8];
            state_d = StAccess;
          end else begin
            state_d = StError;
          end
        end
      end
      StAccess: begin
        // A ready arriving on the timeout cycle still completes normally.
        if (sel_ready) begin
          rdata_d = slot_rdata;
          p_sel_d = '0;
          state_d = StResp;
        end else if (cnt_q == TimeoutM1) begin
          p_sel_d = '0;
          state_d = StError;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StError: begin
        rdata_d    = ERR_DATA;
        last_err_d = addr_q;
        p_sel_d    = '0;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        state_d    = StResp;
      end
      StResp: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      p_sel_q    <= '0;
      wstrb_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      err_cnt_q  <= '0;
      last_err_q <= '0;
    end else begin
      state_q    <= state_d;
      p_sel_q    <= p_sel_d;
      wstrb_q    <= wstrb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      last_err_q <= last_err_d;
    end
  end

  // Ready decodes straight from state so an async reset drops it immediately.
  assign bus.iomem_ready = (state_q == StResp);
  assign bus.iomem_rdata = rdata_q;
  assign bus.p_sel       = p_sel_q;
  assign bus.p_wstrb     = wstrb_q;
  assign bus.p_addr      = addr_q[7:0];
  assign bus.p_wdata     = wdata_q;
  assign err_count       = err_cnt_q;
  assign last_err_addr   = last_err_q;

endmodule

// File: tb/tb_iomem_slot_arbiter.sv
// Randomized and directed checks of iomem_slot_arbiter against a transaction-level model
// (expected select cycles, read data and error bookkeeping per request).
module tb_iomem_slot_arbiter;

  localparam int unsigned NS      = 8;
  localparam logic [15:0] BASE    = 16'h0300;
  localparam int unsigned TMO     = 4;
  localparam logic [31:0] ERR     = 32'hDEADBEEF;

  logic        clk;
  logic        reset;
  logic [7:0]  err_count;
  logic [31:0] last_err_addr;

  iomem_slot_arbiter_if #(.NUM_SLOTS(NS)) bus ();

  iomem_slot_arbiter #(
    .NUM_SLOTS(NS),
    .BASE_ADDR(BASE),
    .TIMEOUT  (TMO),
    .ERR_DATA (ERR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .err_count    (err_count),
    .last_err_addr(last_err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model state: slot contents and error bookkeeping.
  logic [31:0] slot_data [NS];
  int unsigned m_err  = 0;
  logic [31:0] m_last = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_slots();
    for (int i = 0; i < NS; i++) bus.p_rdata[32*i +: 32] = slot_data[i];
  endtask

  // One CPU request. dly = p_sel cycles that pass before the slot raises p_ready.
  task automatic run_txn(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                         input int dly);
    logic          ours;
    logic          mapped;
    logic          timed_out;
    int            slot;
    logic [NS-1:0] onehot;
    logic [NS-1:0] noise;
    int            exp_sel;
    logic [31:0]   exp_rd;
    int            sel_cyc;
    int            ready_cnt;
    logic [31:0]   rd;

    ours      = (a[31:16] == BASE);
    slot      = int'(a[15:8]);
    mapped    = ours && (slot < NS);
    onehot    = mapped ? (NS'(1) << slot) : '0;
    timed_out = mapped && (dly >= int'(TMO));
    exp_sel   = !mapped ? 0 : (timed_out ? int'(TMO) : dly + 1);
    exp_rd    = (mapped && !timed_out) ? slot_data[slot] : ERR;
    if (ours && (!mapped || timed_out)) begin
      if (m_err < 255) m_err++;
      m_last = a;
    end

    @(negedge clk);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = a;
    bus.iomem_wstrb = ws;
    bus.iomem_wdata = wd;
    noise           = NS'($urandom);
    bus.p_ready     = noise & ~onehot;

    sel_cyc   = 0;
    ready_cnt = 0;
    rd        = '0;
    for (int c = 0; c < int'(TMO) + 20 && ready_cnt == 0; c++) begin
      @(posedge clk);
      #1;
      if (bus.p_sel != '0) begin
        sel_cyc++;
        check_eq("p_sel", 32'(bus.p_sel), 32'(onehot));
        check_eq("p_addr", 32'(bus.p_addr), 32'(a[7:0]));
        check_eq("p_wstrb", 32'(bus.p_wstrb), 32'(ws));
        check_eq("p_wdata", bus.p_wdata, wd);
      end
      if (bus.iomem_ready) begin
        ready_cnt++;
        rd = bus.iomem_rdata;
        bus.iomem_valid = 1'b0;
      end
      noise = NS'($urandom);
      bus.p_ready = noise & ~onehot;
      if (bus.p_sel != '0 && sel_cyc - 1 >= dly) bus.p_ready = bus.p_ready | onehot;
    end
    bus.iomem_valid = 1'b0;
    bus.p_ready     = '0;

    check_eq("sel_cycles", 32'(sel_cyc), 32'(exp_sel));
    if (ours) begin
      check_eq("ready_seen", 32'(ready_cnt), 32'd1);
      check_eq("rdata", rd, exp_rd);
      @(posedge clk);
      #1;
      check_eq("ready_single", 32'(bus.iomem_ready), 32'd0);
    end else begin
      check_eq("foreign_ready", 32'(ready_cnt), 32'd0);
    end
    check_eq("err_count", 32'(err_count), 32'(m_err));
    check_eq("last_err_addr", last_err_addr, m_last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  ws;
    logic [7:0]  slot;

    reset           = 1'b1;
    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = '0;
    bus.iomem_wstrb = '0;
    bus.iomem_wdata = '0;
    bus.p_ready     = '0;
    for (int i = 0; i < NS; i++) slot_data[i] = $urandom;
    load_slots();

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(bus.iomem_ready), 32'd0);
    check_eq("rst_p_sel", 32'(bus.p_sel), 32'd0);
    check_eq("rst_rdata", bus.iomem_rdata, 32'd0);
    check_eq("rst_p_addr", 32'(bus.p_addr), 32'd0);
    check_eq("rst_p_wdata", bus.p_wdata, 32'd0);
    check_eq("rst_err_count", 32'(err_count), 32'd0);
    check_eq("rst_last_err", last_err_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases.
    slot_data[2] = 32'h1234_5678;
    load_slots();
    run_txn(32'h0300_0204, 4'b0000, 32'h0, 0);
    run_txn(32'h0300_0100, 4'b0011, 32'hA5A5_00FF, 5);
    run_txn(32'h0300_0900, 4'b0000, 32'h0, 0);
    run_txn(32'h0300_0800, 4'b1111, 32'h5555_AAAA, 0);
    run_txn(32'h0300_0300, 4'b0000, 32'h0, 100);
    run_txn(32'h0300_0310, 4'b0000, 32'h0, int'(TMO) - 1);
    run_txn(32'h0400_0000, 4'b0000, 32'h0, 0);
    run_txn(32'h0300_07FC, 4'b1000, 32'hCAFE_F00D, 2);

    // Async reset while slot 3 is being accessed.
    @(negedge clk);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h0300_0300;
    bus.iomem_wstrb = 4'b0000;
    bus.p_ready     = '0;
    @(posedge clk);
    #1;
    check_eq("pre_rst_p_sel", 32'(bus.p_sel), 32'h8);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_p_sel", 32'(bus.p_sel), 32'd0);
    check_eq("mid_rst_ready", 32'(bus.iomem_ready), 32'd0);
    check_eq("mid_rst_err_count", 32'(err_count), 32'd0);
    check_eq("mid_rst_last_err", last_err_addr, 32'd0);
    bus.iomem_valid = 1'b0;
    m_err  = 0;
    m_last = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("post_rst_ready", 32'(bus.iomem_ready), 32'd0);
    run_txn(32'h0300_0308, 4'b0000, 32'h0, 1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NS; i++) slot_data[i] = $urandom;
      load_slots();
      slot = 8'($urandom_range(0, NS + 3));
      a    = {BASE, slot, 8'($urandom)};
      if ($urandom_range(0, 9) == 0) a[31:16] = 16'($urandom_range(16'h0400, 16'hFFFF));
      ws   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      run_txn(a, ws, $urandom, int'($urandom_range(0, TMO + 1)));
    end

    // Error counter saturation.
    for (int n = 0; n < 300; n++) begin
      a = {BASE, 8'($urandom_range(NS, 255)), 8'($urandom)};
      run_txn(a, 4'($urandom), $urandom, 0);
    end
    check_eq("err_saturated", 32'(err_count), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
